// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 write-back / register-file slice.
//   XLEN      : datapath width
//   wb_sel_e  : write-back result select encoding (2'b11 aliases ALU)
//   F3_*      : load funct3 encodings handled by load_extend
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Load data extraction and sign/zero extension (purely combinational).
//   funct3 : load type (LB/LH/LW/LBU/LHU; anything else passes raw word)
//   offset : byte offset within the aligned word
//   raw    : aligned word from data memory
//   ext    : extracted, extended load value
module load_extend
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword select uses only offset[1]; offset[0] is ignored for LH/LHU.
  always_comb begin
    byte_sel = raw[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? raw[31:16] : raw[15:0];
  end

  always_comb begin
    ext = raw;
    unique case (funct3)
      F3_LB:   ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LW:   ext = raw;
      F3_LBU:  ext = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  ext = {{(XLEN-16){1'b0}}, half_sel};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus architectural register file.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_validW, i_reg_wenW  : W-stage valid / writes rd
//   i_wb_selW             : result select (ALU / load / PC+4)
//   i_funct3W, i_ld_dataW : load type and raw memory word
//   i_alu_dataW           : ALU result (also load byte address)
//   i_pc_fourW            : link value
//   i_rd_addrW            : destination register
//   i_rs1_addrD/i_rs2_addrD, o_rs1_dataD/o_rs2_dataD : decode read ports
//   o_wb_dataW            : selected write-back value (for forwarding)
//   o_instret             : retired-instruction counter
module wb_regfile
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = riscv_pkg::XLEN,
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_validW,
  input  logic             i_reg_wenW,
  input  logic [1:0]       i_wb_selW,
  input  logic [2:0]       i_funct3W,
  input  logic [XLEN-1:0]  i_ld_dataW,
  input  logic [XLEN-1:0]  i_alu_dataW,
  input  logic [XLEN-1:0]  i_pc_fourW,
  input  logic [4:0]       i_rd_addrW,
  input  logic [4:0]       i_rs1_addrD,
  input  logic [4:0]       i_rs2_addrD,
  output logic [XLEN-1:0]  o_rs1_dataD,
  output logic [XLEN-1:0]  o_rs2_dataD,
  output logic [XLEN-1:0]  o_wb_dataW,
  output logic [CNT_W-1:0] o_instret
);

  logic [XLEN-1:0]  regs [NREG];
  logic [XLEN-1:0]  ld_ext;
  logic [CNT_W-1:0] instret_q;
  logic             wr_en;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3 (i_funct3W),
    .offset (i_alu_dataW[1:0]),
    .raw    (i_ld_dataW),
    .ext    (ld_ext)
  );

  always_comb begin
    o_wb_dataW = i_alu_dataW;
    case (wb_sel_e'(i_wb_selW))
      WB_LOAD: o_wb_dataW = ld_ext;
      WB_PC4:  o_wb_dataW = i_pc_fourW;
      default: o_wb_dataW = i_alu_dataW;
    endcase
  end

  assign wr_en = i_validW & i_reg_wenW & (i_rd_addrW != 5'd0) & ~i_rst;

  // Write-first bypass: a same-cycle write to the addressed register wins over the array.
  always_comb begin
    o_rs1_dataD = '0;
    o_rs2_dataD = '0;
    if (!i_rst) begin
      if (i_rs1_addrD == 5'd0)
        o_rs1_dataD = '0;
      else if (wr_en && (i_rs1_addrD == i_rd_addrW))
        o_rs1_dataD = o_wb_dataW;
      else
        o_rs1_dataD = regs[i_rs1_addrD];

      if (i_rs2_addrD == 5'd0)
        o_rs2_dataD = '0;
      else if (wr_en && (i_rs2_addrD == i_rd_addrW))
        o_rs2_dataD = o_wb_dataW;
      else
        o_rs2_dataD = regs[i_rs2_addrD];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[i_rd_addrW] <= o_wb_dataW;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      instret_q <= '0;
    else if (i_validW)
      instret_q <= instret_q + 1'b1;
  end

  assign o_instret = instret_q;

endmodule
